// File: rtl/alu_rs.sv
// ALU reservation station: an age-ordered compacting queue of renamed ALU ops.
// It wakes sources from the completion broadcast and issues the oldest ready entry each cycle.
module alu_rs #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 6,
  parameter int ROB_W = 4,
  parameter int IMM_W = 16,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             isDispatch,
  input  logic [ROB_W-1:0] rob_num_dp,
  input  logic [TAG_W-1:0] p_rd_new,
  input  logic             RegDest,
  input  logic [TAG_W-1:0] p_rs,
  input  logic [TAG_W-1:0] p_rt,
  input  logic             p_rs_v,
  input  logic             p_rt_v,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [IMM_W-1:0] immed,
  input  logic             hazard_stall,
  input  logic             complete,
  input  logic [TAG_W-1:0] p_rd_compl,
  input  logic             RegDest_compl,
  input  logic             recover,
  input  logic [ROB_W-1:0] rob_num_rec,
  output logic             issue,
  output logic [TAG_W-1:0] p_rs_out,
  output logic [TAG_W-1:0] p_rt_out,
  output logic [TAG_W-1:0] p_rd_out,
  output logic [ROB_W-1:0] rob_num_out,
  output logic [OP_W-1:0]  alu_op_out,
  output logic [IMM_W-1:0] immed_out,
  output logic             RegDest_out,
  output logic             rs_full
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] rs;
    logic [TAG_W-1:0] rt;
    logic [TAG_W-1:0] rd;
    logic             rs_rdy;
    logic             rt_rdy;
    logic [ROB_W-1:0] rob;
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
    logic             reg_dest;
  } entry_t;

  entry_t           ent     [DEPTH];
  entry_t           ent_nxt [DEPTH];
  logic [DEPTH-1:0] vld, vld_nxt, remove;
  logic [CW-1:0]    count, count_nxt, k;
  logic [IW-1:0]    sel;
  logic             wake, accept, found, do_issue;

  assign rs_full  = (count == CW'(DEPTH));
  assign wake     = complete & RegDest_compl;
  assign accept   = isDispatch & ~rs_full & ~hazard_stall & ~recover;
  assign do_issue = found & ~hazard_stall & ~recover;

  // Oldest-first select over registered state only, so a same-cycle wakeup cannot be picked.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && vld[i] && ent[i].rs_rdy && ent[i].rt_rdy) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  always_comb begin
    remove = '0;
    if (recover) begin
      for (int i = 0; i < DEPTH; i++)
        remove[i] = vld[i] && (ent[i].rob == rob_num_rec);
    end else if (do_issue) begin
      remove[sel] = 1'b1;
    end
  end

  // Survivors slide down in age order; the new entry lands right behind them.
  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    vld_nxt = '0;
    k       = '0;
    for (int i = 0; i < DEPTH; i++) ent_nxt[i] = ent[i];
    for (int j = 0; j < DEPTH; j++) begin
      if (vld[j] && !remove[j]) begin
        ent_nxt[k[IW-1:0]] = ent[j];
        if (wake && ent[j].rs == p_rd_compl) ent_nxt[k[IW-1:0]].rs_rdy = 1'b1;
        if (wake && ent[j].rt == p_rd_compl) ent_nxt[k[IW-1:0]].rt_rdy = 1'b1;
        vld_nxt[k[IW-1:0]] = 1'b1;
        k = k + CW'(1);
      end
    end
    if (accept) begin
      ent_nxt[k[IW-1:0]].rs       = p_rs;
      ent_nxt[k[IW-1:0]].rt       = p_rt;
      ent_nxt[k[IW-1:0]].rd       = p_rd_new;
      ent_nxt[k[IW-1:0]].rs_rdy   = p_rs_v | (wake && p_rs == p_rd_compl);
      ent_nxt[k[IW-1:0]].rt_rdy   = p_rt_v | (wake && p_rt == p_rd_compl);
      ent_nxt[k[IW-1:0]].rob      = rob_num_dp;
      ent_nxt[k[IW-1:0]].op       = alu_op;
      ent_nxt[k[IW-1:0]].imm      = immed;
      ent_nxt[k[IW-1:0]].reg_dest = RegDest;
      vld_nxt[k[IW-1:0]]          = 1'b1;
    end
    count_nxt = k + CW'(accept);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      count <= '0;
    end else begin
      vld   <= vld_nxt;
      count <= count_nxt;
    end
  end

  // NOTE: payload storage is not reset; the valid bits alone decide whether a slot means anything.
  always_ff @(posedge clk) begin
    ent <= ent_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue       <= 1'b0;
      p_rs_out    <= '0;
      p_rt_out    <= '0;
      p_rd_out    <= '0;
      rob_num_out <= '0;
      alu_op_out  <= '0;
      immed_out   <= '0;
      RegDest_out <= 1'b0;
    end else begin
      issue <= do_issue;
      if (do_issue) begin
        p_rs_out    <= ent[sel].rs;
        p_rt_out    <= ent[sel].rt;
        p_rd_out    <= ent[sel].rd;
        rob_num_out <= ent[sel].rob;
        alu_op_out  <= ent[sel].op;
        immed_out   <= ent[sel].imm;
        RegDest_out <= ent[sel].reg_dest;
      end
    end
  end

endmodule
